branch_resolver: RTL and testbench

- Consumer end of the ALU flag interface.
- Latches the LT/GT/EQ compare flags the ALU produces on CMP and evaluates conditional-branch requests from decode against them.
- Computes the PC-relative target and drives a valid/ready redirect to the fetch unit.
- Sits between the execute stage (flag writer) and fetch (PC redirect consumer).

---
 rtl/branch_resolver_pkg.sv | 8 +
 rtl/branch_resolver_if.sv | 29 ++
 rtl/branch_cond_eval.sv | 27 ++
 rtl/branch_resolver.sv | 78 +++++++
 tb/tb_branch_resolver.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared condition codes, flag bit positions and FSM states
package branch_resolver_pkg;
  typedef enum logic [2:0] {ALWAYS, EQ, NE, LT, GT, LE, GE, NEVER} br_cond_t;
  localparam int kFLAG_LT = 2;
  localparam int kFLAG_GT = 1;
  localparam int kFLAG_EQ = 0;
  typedef enum logic {IDLE, REDIRECT} br_state_t;
endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: ALU flags, decode branch request and fetch redirect bundle
interface branch_resolver_if #(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int PC_WIDTH = 8
);
  logic flag_we;
  logic lt_in;
  logic gt_in;
  logic eq_in;
  logic br_valid;
  logic br_ready;
  logic [2:0] br_cond;
  logic [PC_WIDTH-1:0] br_pc;
  logic [DATA_PATH_WIDTH-1:0] br_offset;
  logic redirect_valid;
  logic redirect_ready;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic resolved_valid;
  logic resolved_taken;
  logic [2:0] flags_q;
  modport master (
    output flag_we, lt_in, gt_in, eq_in, br_valid, br_cond, br_pc, br_offset, redirect_ready,
    input br_ready, redirect_valid, redirect_pc, resolved_valid, resolved_taken, flags_q
  );
  modport slave (
    input flag_we, lt_in, gt_in, eq_in, br_valid, br_cond, br_pc, br_offset, redirect_ready,
    output br_ready, redirect_valid, redirect_pc, resolved_valid, resolved_taken, flags_q
  );
endinterface

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: evaluates a condition code against {LT,GT,EQ} flags
module branch_cond_eval
  import branch_resolver_pkg::*;
(
  input  br_cond_t   cond,
  input  logic [2:0] flags,
  output logic       taken
);
  logic lt, gt, eq;
  assign lt = flags[kFLAG_LT];
  assign gt = flags[kFLAG_GT];
  assign eq = flags[kFLAG_EQ];
  // one result per condition code; flags are used as stored, even if not one-hot
  always_comb begin
    taken = 1'b0;
    case (cond)
      ALWAYS: taken = 1'b1;
      EQ:     taken = eq;
      NE:     taken = !eq;
      LT:     taken = lt;
      GT:     taken = gt;
      LE:     taken = lt | eq;
      GE:     taken = gt | eq;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: latches ALU flags, resolves branches, drives fetch redirect (optional BRANCH_STATS_EN counters)
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int PC_WIDTH = 8,
  parameter int COUNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  branch_resolver_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] resolved_count,
  output logic [COUNT_WIDTH-1:0] taken_count
`endif
);
  if (PC_WIDTH < DATA_PATH_WIDTH || COUNT_WIDTH < 1) begin : g_bad_params
    $error("branch_resolver: PC_WIDTH must be >= DATA_PATH_WIDTH and COUNT_WIDTH >= 1");
  end
  br_state_t state;
  logic [2:0] flags_q, flags_in, flags_eff;
  logic ready, accept, taken;
  logic signed [DATA_PATH_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0] target;
  assign flags_in = {bus.lt_in, bus.gt_in, bus.eq_in};
  assign flags_eff = bus.flag_we ? flags_in : flags_q;
  assign ready = state == IDLE;
  assign accept = bus.br_valid && ready;
  assign offset = bus.br_offset;
  assign target = bus.br_pc + PC_WIDTH'(offset);
  assign bus.br_ready = ready;
  assign bus.flags_q = flags_q;
  branch_cond_eval u_eval (
    .cond(br_cond_t'(bus.br_cond)),
    .flags(flags_eff),
    .taken(taken)
  );
  // flag latch, resolve pulse and IDLE/REDIRECT handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      flags_q <= 3'b000;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc <= '0;
      bus.resolved_valid <= 1'b0;
      bus.resolved_taken <= 1'b0;
    end else begin
      if (bus.flag_we) flags_q <= flags_in;
      bus.resolved_valid <= accept;
      bus.resolved_taken <= accept && taken;
      case (state)
        IDLE: if (accept && taken) begin
          state <= REDIRECT;
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc <= target;
        end
        REDIRECT: if (bus.redirect_ready) begin
          state <= IDLE;
          bus.redirect_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BRANCH_STATS_EN
  // saturating counts of accepted and taken branches
  always_ff @(posedge clk) begin
    if (reset) begin
      resolved_count <= '0;
      taken_count <= '0;
    end else begin
      if (accept && !(&resolved_count)) resolved_count <= resolved_count + 1'b1;
      if (accept && taken && !(&taken_count)) taken_count <= taken_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed plan plus randomized run against a transaction-level model
module tb_branch_resolver;
  import branch_resolver_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  branch_resolver_if #(.DATA_PATH_WIDTH(8), .PC_WIDTH(8)) bus ();
`ifdef BRANCH_STATS_EN
  logic [15:0] resolved_count, taken_count;
`endif
  branch_resolver #(.DATA_PATH_WIDTH(8), .PC_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef BRANCH_STATS_EN
    ,
    .resolved_count(resolved_count),
    .taken_count(taken_count)
`endif
  );
  int n_chk = 0, n_pass = 0;
  int m_flags = 0, m_target = 0, n_acc = 0, n_tk = 0;
  bit m_busy = 0, e_rv = 0, e_rt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit cond_ok(input int c, input int f);
    bit lt, gt, eq;
    lt = (f / 4) % 2;
    gt = (f / 2) % 2;
    eq = f % 2;
    case (c)
      0: return 1;
      1: return eq;
      2: return !eq;
      3: return lt;
      4: return gt;
      5: return lt || eq;
      6: return gt || eq;
      default: return 0;
    endcase
  endfunction

  task automatic verify();
    check("br_ready", bus.br_ready, !m_busy);
    check("redirect_valid", bus.redirect_valid, m_busy);
    if (m_busy) check("redirect_pc", bus.redirect_pc, m_target);
    check("resolved_valid", bus.resolved_valid, e_rv);
    if (e_rv) check("resolved_taken", bus.resolved_taken, e_rt);
    check("flags_q", bus.flags_q, m_flags);
  endtask

  task automatic step(input bit we, input int fl, input bit bv, input int c, input int pc, input int off, input bit rr);
    int f, soff;
    bit acc, tk;
    bus.flag_we = we;
    bus.lt_in = fl[2];
    bus.gt_in = fl[1];
    bus.eq_in = fl[0];
    bus.br_valid = bv;
    bus.br_cond = c[2:0];
    bus.br_pc = pc[7:0];
    bus.br_offset = off[7:0];
    bus.redirect_ready = rr;
    f = we ? fl : m_flags;
    acc = bv && !m_busy;
    tk = cond_ok(c, f);
    e_rv = acc;
    e_rt = acc && tk;
    if (we) m_flags = fl;
    soff = (off & 255) >= 128 ? (off & 255) - 256 : (off & 255);
    if (m_busy) m_busy = !rr;
    else if (acc && tk) begin
      m_busy = 1;
      m_target = (pc + soff + 256) % 256;
    end
    if (acc) n_acc++;
    if (acc && tk) n_tk++;
    @(posedge clk);
    #1;
    verify();
  endtask

  task automatic idle(input bit rr);
    step(0, 0, 0, 0, 0, 0, rr);
  endtask

  task automatic do_reset();
    reset = 1;
    bus.flag_we = 0; bus.lt_in = 0; bus.gt_in = 0; bus.eq_in = 0;
    bus.br_valid = 0; bus.br_cond = 0; bus.br_pc = 0; bus.br_offset = 0;
    bus.redirect_ready = 0;
    @(posedge clk);
    #1;
    reset = 0;
    m_flags = 0; m_busy = 0; e_rv = 0; e_rt = 0; n_acc = 0; n_tk = 0;
    verify();
  endtask

  initial begin
    do_reset();
    check("rst_redirect_pc", bus.redirect_pc, 0);
    check("rst_resolved_taken", bus.resolved_taken, 0);
    // CMP then branch LT, no bypass
    step(1, 3'b100, 0, 0, 0, 0, 1);
    step(0, 0, 1, LT, 8'h10, 8'h05, 1);
    check("tp1_taken", bus.resolved_taken, 1);
    check("tp1_target", bus.redirect_pc, 8'h15);
    check("tp1_ready_low", bus.br_ready, 0);
    idle(1);
    check("tp1_redirect_done", bus.redirect_valid, 0);
    check("tp1_ready_back", bus.br_ready, 1);
    // same-cycle bypass over old flags 100
    step(1, 3'b100, 0, 0, 0, 0, 1);
    step(1, 3'b001, 1, NE, 8'h40, 8'h10, 1);
    check("bypass_taken", bus.resolved_taken, 0);
    check("bypass_no_redirect", bus.redirect_valid, 0);
    check("bypass_flags", bus.flags_q, 3'b001);
    // wrap-around both directions
    step(0, 0, 1, ALWAYS, 8'hFE, 8'h04, 1);
    check("wrap_fwd", bus.redirect_pc, 8'h02);
    idle(1);
    step(0, 0, 1, ALWAYS, 8'h01, 8'hFD, 1);
    check("wrap_back", bus.redirect_pc, 8'hFE);
    idle(1);
    // backpressure with second branch held
    step(0, 0, 1, ALWAYS, 8'h20, 8'h10, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, NEVER, 8'h50, 8'h01, 0);
      check("bp_hold_pc", bus.redirect_pc, 8'h30);
      check("bp_hold_ready", bus.br_ready, 0);
    end
    step(0, 0, 1, NEVER, 8'h50, 8'h01, 1);
    check("bp_handshake_noacc", bus.resolved_valid, 0);
    check("bp_ready_back", bus.br_ready, 1);
    step(0, 0, 1, NEVER, 8'h50, 8'h01, 1);
    check("bp_second_acc", bus.resolved_valid, 1);
    check("bp_second_nt", bus.resolved_taken, 0);
    // reset while a redirect is pending, flag write during redirect
    step(0, 0, 1, ALWAYS, 8'h80, 8'h08, 0);
    step(1, 3'b010, 0, 0, 0, 0, 0);
    check("redir_flag_we_pc", bus.redirect_pc, 8'h88);
    do_reset();
    check("mid_rst_valid", bus.redirect_valid, 0);
    check("mid_rst_flags", bus.flags_q, 0);
    check("mid_rst_ready", bus.br_ready, 1);
    step(0, 0, 1, NEVER, 8'h10, 8'h01, 1);
    check("never_nt", bus.resolved_taken, 0);
    step(0, 0, 1, GE, 8'h10, 8'h01, 1);
    check("ge_zero_nt", bus.resolved_taken, 0);
`ifdef BRANCH_STATS_EN
    do_reset();
    step(0, 0, 1, ALWAYS, 8'h00, 8'h01, 1);
    idle(1);
    step(0, 0, 1, NEVER, 8'h00, 8'h01, 1);
    step(0, 0, 1, ALWAYS, 8'h00, 8'h01, 1);
    idle(1);
    step(0, 0, 1, NEVER, 8'h00, 8'h01, 1);
    step(0, 0, 1, ALWAYS, 8'h00, 8'h01, 1);
    idle(1);
    check("stats_resolved", resolved_count, 5);
    check("stats_taken", taken_count, 3);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 9) < 7);
`ifdef BRANCH_STATS_EN
      check("rnd_resolved_count", resolved_count, n_acc);
      check("rnd_taken_count", taken_count, n_tk);
`endif
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
